instr_encoder: RTL and testbench

- Encoder counterpart to the main control decoder. Takes symbolic instruction requests (kind, registers, immediate) and emits 32-bit LEGv8 machine words with byte addresses for loading instruction memory.
- Sits between the test/boot loader and the instruction-memory write port. Every word it produces decodes, through the main decoder, back to the requested control class.
- Single registered output stage, valid/ready on both sides, slot counter with full detection, immediate range checking.

---
 rtl/instr_pkg.sv | 65 ++++++
 rtl/instr_format.sv | 61 ++++++
 rtl/instr_encoder.sv | 108 ++++++++++
 tb/tb_instr_encoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the LEGv8 instruction encoder and the main decoder:
// instruction kinds, opcode constants, instruction formats, field positions
// and the D-format immediate range helper.
package instr_pkg;

    // Symbolic instruction kinds as presented on in_kind
    typedef enum logic [2:0] {
        K_ADD  = 3'd0,
        K_SUB  = 3'd1,
        K_AND  = 3'd2,
        K_ORR  = 3'd3,
        K_LDUR = 3'd4,
        K_STUR = 3'd5,
        K_CBZ  = 3'd6,
        K_MOVZ = 3'd7
    } kind_e;

    // Machine-word layout families
    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_D  = 2'd1,
        FMT_CB = 2'd2,
        FMT_IW = 2'd3
    } fmt_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;

    // Least-significant bit of each field inside the 32-bit word
    localparam int OPC11_LSB = 21;  // R and D opcodes
    localparam int OPC8_LSB  = 24;  // CB opcode
    localparam int OPC9_LSB  = 23;  // IW opcode
    localparam int RM_LSB    = 16;
    localparam int DIMM_LSB  = 12;
    localparam int CBIMM_LSB = 5;
    localparam int IWIMM_LSB = 5;
    localparam int HW_LSB    = 21;
    localparam int RN_LSB    = 5;
    localparam int RD_LSB    = 0;

    // Map a kind onto its word layout
    function automatic fmt_e kind_fmt(input kind_e kind);
        fmt_e f;
        case (kind)
            K_ADD, K_SUB, K_AND, K_ORR: f = FMT_R;
            K_LDUR, K_STUR:             f = FMT_D;
            K_CBZ:                      f = FMT_CB;
            K_MOVZ:                     f = FMT_IW;
            default:                    f = FMT_R;
        endcase
        return f;
    endfunction

    // A 19-bit value fits the 9-bit signed D offset when bits 18:8 are a sign extension
    function automatic logic d_imm_in_range(input logic [18:0] imm);
        return (&imm[18:8]) | (~|imm[18:8]);
    endfunction

endpackage

// File: rtl/instr_format.sv
// Purely combinational field packer: kind + register/immediate fields ->
// 32-bit LEGv8 word plus a flag for an out-of-range immediate.
// Ports: kind/rd/rn/rm/imm/hw in, word/range_err out.
module instr_format
    import instr_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [18:0] imm,
    input  logic [1:0]  hw,
    output logic [31:0] word,
    output logic        range_err
);

    kind_e kind_s;
    assign kind_s = kind_e'(kind);

    // Opcode and format-specific field placement
    always_comb begin
        word      = 32'd0;
        range_err = 1'b0;
        // Rd / Rt always occupies bits 4:0
        word[RD_LSB +: 5] = rd;
        case (kind_s)
            K_ADD:   word[OPC11_LSB +: 11] = OP_ADD;
            K_SUB:   word[OPC11_LSB +: 11] = OP_SUB;
            K_AND:   word[OPC11_LSB +: 11] = OP_AND;
            K_ORR:   word[OPC11_LSB +: 11] = OP_ORR;
            K_LDUR:  word[OPC11_LSB +: 11] = OP_LDUR;
            K_STUR:  word[OPC11_LSB +: 11] = OP_STUR;
            K_CBZ:   word[OPC8_LSB  +: 8]  = OP_CBZ;
            K_MOVZ:  word[OPC9_LSB  +: 9]  = OP_MOVZ;
            default: word[OPC11_LSB +: 11] = 11'd0;
        endcase
        case (kind_fmt(kind_s))
            FMT_R: begin
                word[RM_LSB +: 5] = rm;
                word[RN_LSB +: 5] = rn;
            end
            FMT_D: begin
                word[DIMM_LSB +: 9] = imm[8:0];
                word[RN_LSB +: 5]   = rn;
                range_err           = ~d_imm_in_range(imm);
            end
            FMT_CB: begin
                word[CBIMM_LSB +: 19] = imm;
            end
            FMT_IW: begin
                word[HW_LSB +: 2]     = hw;
                word[IWIMM_LSB +: 16] = imm[15:0];
                range_err             = |imm[18:16];
            end
            default: begin
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Symbolic-request to LEGv8 machine-word encoder feeding an instruction
// memory write port. One registered output stage with valid/ready on both
// sides, a slot counter that stops after DEPTH words, and immediate range
// rejection with a saturating error counter.
// Ports: clk, reset (sync, active-high), start (restart at BASE_ADDR),
//        in_valid/in_ready + in_kind/in_rd/in_rn/in_rm/in_imm/in_hw request,
//        out_valid/out_ready + out_addr/out_word result,
//        full, err (one-cycle reject pulse), err_count.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [18:0]       in_imm,
    input  logic [1:0]        in_hw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam int                SLOT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    logic [SLOT_W-1:0] slot_r;
    logic [SLOT_W-1:0] slot_next_s;
    logic [ADDR_W-1:0] slot_addr_s;
    logic [31:0]       word_s;
    logic              range_err_s;
    logic              accept_s;
    logic              load_s;

    instr_format u_format (
        .kind      (in_kind),
        .rd        (in_rd),
        .rn        (in_rn),
        .rm        (in_rm),
        .imm       (in_imm),
        .hw        (in_hw),
        .word      (word_s),
        .range_err (range_err_s)
    );

    // A free output slot exists when the register is empty or draining this cycle
    assign in_ready    = ~reset & ~start & ~full & (~out_valid | out_ready);
    assign accept_s    = in_valid & in_ready;
    assign load_s      = accept_s & ~range_err_s;
    assign slot_next_s = slot_r + SLOT_W'(1);
    assign slot_addr_s = BASE_A + (ADDR_W'(slot_r) << 2);

    // Output register, slot counter and full flag
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_addr  <= BASE_A;
            out_word  <= 32'd0;
            slot_r    <= '0;
            full      <= 1'b0;
        end else if (start) begin
            out_valid <= 1'b0;
            slot_r    <= '0;
            full      <= 1'b0;
        end else if (load_s) begin
            // Also covers drain-and-refill in the same edge
            out_valid <= 1'b1;
            out_addr  <= slot_addr_s;
            out_word  <= word_s;
            slot_r    <= slot_next_s;
            full      <= (slot_next_s == SLOT_W'(DEPTH));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Reject pulse and saturating reject counter; start leaves the count alone
    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (start) begin
            err       <= 1'b0;
        end else begin
            err <= accept_s & range_err_s;
            if (accept_s && range_err_s && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end else begin
                err_count <= err_count;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, out_ready;
    logic        in_ready, out_valid, full, err;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd, in_rn, in_rm;
    logic [18:0] in_imm;
    logic [1:0]  in_hw;
    logic [31:0] out_addr, out_word;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid, m_full, m_err;
    logic [31:0] m_word, m_addr;
    int          m_slot, m_errcnt;
    bit          m_addr_known;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
        .in_imm(in_imm), .in_hw(in_hw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_word(out_word),
        .full(full), .err(err), .err_count(err_count)
    );

    // Arithmetic encoding straight from the field layouts
    function automatic void ref_encode(input logic [2:0] k, input logic [4:0] rd,
                                       input logic [4:0] rn, input logic [4:0] rm,
                                       input logic [18:0] imm, input logic [1:0] hw,
                                       output logic [31:0] w, output bit bad);
        longint acc;
        int     v;
        v = int'(imm);
        if (imm[18]) v = v - 524288;
        bad = 1'b0;
        case (k)
            3'd0: acc = 64'h458 * 2097152 + rm * 65536 + rn * 32 + rd;
            3'd1: acc = 64'h658 * 2097152 + rm * 65536 + rn * 32 + rd;
            3'd2: acc = 64'h450 * 2097152 + rm * 65536 + rn * 32 + rd;
            3'd3: acc = 64'h550 * 2097152 + rm * 65536 + rn * 32 + rd;
            3'd4, 3'd5: begin
                bad = (v < -256) || (v > 255);
                acc = ((k == 3'd4) ? 64'h7C2 : 64'h7C0) * 2097152
                      + (v & 511) * 4096 + rn * 32 + rd;
            end
            3'd6: acc = 64'hB4 * 16777216 + imm * 32 + rd;
            default: begin
                bad = (imm > 19'h0FFFF);
                acc = 64'h1A5 * 8388608 + hw * 2097152 + (imm % 65536) * 32 + rd;
            end
        endcase
        w = acc[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check in_ready before the edge, advance model, check outputs after
    task automatic step();
        bit          rdy, acc, bad;
        logic [31:0] w;
        @(negedge clk);
        rdy = !reset && !start && !m_full && (!m_valid || out_ready);
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_word = 32'd0; m_addr = 32'd0; m_slot = 0;
            m_full = 0; m_err = 0; m_errcnt = 0; m_addr_known = 1;
        end else if (start) begin
            m_valid = 0; m_slot = 0; m_full = 0; m_err = 0;
        end else begin
            acc = in_valid && rdy;
            ref_encode(in_kind, in_rd, in_rn, in_rm, in_imm, in_hw, w, bad);
            m_err = acc && bad;
            if (acc && !bad) begin
                m_valid = 1; m_word = w; m_addr = 32'(4 * m_slot);
                m_slot++; m_full = (m_slot == DEPTH); m_addr_known = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (acc && bad && m_errcnt < 255) m_errcnt++;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("full", full, m_full);
        chk("err", err, m_err);
        chk("err_count", err_count, 32'(m_errcnt));
        if (m_valid || reset) begin
            chk("out_word", out_word, m_word);
            chk("out_addr", out_addr, m_addr);
        end
    endtask

    task automatic set_req(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [18:0] imm, input logic [1:0] hw);
        in_valid = 1'b1; in_kind = k; in_rd = rd; in_rn = rn; in_rm = rm;
        in_imm = imm; in_hw = hw;
    endtask

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd, rn, rm;
        logic [18:0] imm;
        logic [1:0]  hw;
        logic [31:0] word;
        bit          rej;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int          n;
        logic [31:0] ec, last_addr;

        tbl[0]  = '{3'd0, 5'd1,  5'd2,  5'd3,  19'd0,       2'd0, 32'h8B030041, 1'b0};
        tbl[1]  = '{3'd1, 5'd31, 5'd0,  5'd31, 19'd0,       2'd0, 32'hCB1F001F, 1'b0};
        tbl[2]  = '{3'd2, 5'd0,  5'd31, 5'd0,  19'd0,       2'd0, 32'h8A0003E0, 1'b0};
        tbl[3]  = '{3'd3, 5'd7,  5'd8,  5'd9,  19'd0,       2'd0, 32'hAA090107, 1'b0};
        tbl[4]  = '{3'd4, 5'd5,  5'd6,  5'd0,  19'h7FFF8,   2'd0, 32'hF85F80C5, 1'b0};
        tbl[5]  = '{3'd5, 5'd1,  5'd2,  5'd0,  19'd255,     2'd0, 32'hF80FF041, 1'b0};
        tbl[6]  = '{3'd4, 5'd0,  5'd0,  5'd0,  19'h7FF00,   2'd0, 32'hF8500000, 1'b0};
        tbl[7]  = '{3'd4, 5'd0,  5'd0,  5'd0,  19'd300,     2'd0, 32'h0,        1'b1};
        tbl[8]  = '{3'd5, 5'd0,  5'd0,  5'd0,  19'h7FEFF,   2'd0, 32'h0,        1'b1};
        tbl[9]  = '{3'd6, 5'd9,  5'd0,  5'd0,  19'h7FFFE,   2'd0, 32'hB4FFFFC9, 1'b0};
        tbl[10] = '{3'd6, 5'd0,  5'd0,  5'd0,  19'h3FFFF,   2'd0, 32'hB47FFFE0, 1'b0};
        tbl[11] = '{3'd7, 5'd4,  5'd0,  5'd0,  19'h01234,   2'd1, 32'hD2A24684, 1'b0};
        tbl[12] = '{3'd7, 5'd0,  5'd0,  5'd0,  19'h10000,   2'd0, 32'h0,        1'b1};
        tbl[13] = '{3'd7, 5'd31, 5'd0,  5'd0,  19'h0FFFF,   2'd3, 32'hD2FFFFFF, 1'b0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_kind = 3'd0; in_rd = 5'd0; in_rn = 5'd0; in_rm = 5'd0;
        in_imm = 19'd0; in_hw = 2'd0;
        m_valid = 0; m_word = 32'd0; m_addr = 32'd0; m_slot = 0;
        m_full = 0; m_err = 0; m_errcnt = 0; m_addr_known = 1;

        step(); step();
        chk("reset_addr", out_addr, 32'h0);
        chk("reset_errcnt", err_count, 32'h0);
        reset = 1'b0;
        step();

        // Table of single encodings, each from a fresh start
        for (int i = 0; i < 14; i++) begin
            start = 1'b1; step(); start = 1'b0; out_ready = 1'b1;
            set_req(tbl[i].kind, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, tbl[i].hw);
            step();
            in_valid = 1'b0;
            chk("tbl_err", err, 32'(tbl[i].rej));
            chk("tbl_valid", out_valid, 32'(!tbl[i].rej));
            if (!tbl[i].rej) begin
                chk("tbl_word", out_word, tbl[i].word);
                chk("tbl_addr", out_addr, 32'h0);
            end
            step();
        end

        // Back-to-back LDUR, CBZ, MOVZ at consecutive addresses
        start = 1'b1; step(); start = 1'b0; out_ready = 1'b1;
        n = 0;
        foreach (tbl[i]) begin
            if (i == 4 || i == 9 || i == 11) begin
                set_req(tbl[i].kind, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, tbl[i].hw);
                step();
                chk("seq_word", out_word, tbl[i].word);
                chk("seq_addr", out_addr, 32'(4 * n));
                n++;
            end
        end
        in_valid = 1'b0; step();

        // Rejected request does not consume a slot
        start = 1'b1; step(); start = 1'b0;
        ec = 32'(err_count);
        set_req(3'd4, 5'd1, 5'd1, 5'd0, 19'd300, 2'd0);
        step();
        chk("rej_err", err, 32'h1);
        chk("rej_valid", out_valid, 32'h0);
        chk("rej_count", err_count, ec + 32'd1);
        set_req(tbl[0].kind, tbl[0].rd, tbl[0].rn, tbl[0].rm, tbl[0].imm, tbl[0].hw);
        step();
        chk("rej_err_drop", err, 32'h0);
        chk("rej_next_addr", out_addr, 32'h0);
        in_valid = 1'b0; step();

        // Backpressure holds the word, then drain and refill with no bubble
        start = 1'b1; step(); start = 1'b0; out_ready = 1'b0;
        set_req(tbl[0].kind, tbl[0].rd, tbl[0].rn, tbl[0].rm, tbl[0].imm, tbl[0].hw);
        step();
        set_req(tbl[1].kind, tbl[1].rd, tbl[1].rn, tbl[1].rm, tbl[1].imm, tbl[1].hw);
        step(); step();
        chk("hold_word", out_word, tbl[0].word);
        chk("hold_ready", in_ready, 32'h0);
        out_ready = 1'b1;
        step();
        chk("refill_valid", out_valid, 32'h1);
        chk("refill_word", out_word, tbl[1].word);
        chk("refill_addr", out_addr, 32'h4);
        in_valid = 1'b0; step();

        // Fill all DEPTH slots, then restart
        start = 1'b1; step(); start = 1'b0; out_ready = 1'b1;
        ec = 32'(err_count);
        n = 0; last_addr = 32'hFFFFFFFF;
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (i < DEPTH + 2) set_req(3'd0, 5'(i), 5'd2, 5'd3, 19'd0, 2'd0);
            else in_valid = 1'b0;
            step();
            if (out_valid) begin
                n++;
                last_addr = out_addr;
            end
        end
        chk("full_words", 32'(n), 32'(DEPTH));
        chk("full_last_addr", last_addr, 32'(4 * (DEPTH - 1)));
        chk("full_flag", full, 32'h1);
        chk("full_ready", in_ready, 32'h0);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_full", full, 32'h0);
        set_req(tbl[3].kind, tbl[3].rd, tbl[3].rn, tbl[3].rm, tbl[3].imm, tbl[3].hw);
        step();
        chk("restart_addr", out_addr, 32'h0);
        chk("restart_errcnt", err_count, ec);
        in_valid = 1'b0; step();

        // start discards a pending word and blocks a coincident request
        start = 1'b1; step(); start = 1'b0; out_ready = 1'b0;
        set_req(tbl[2].kind, tbl[2].rd, tbl[2].rn, tbl[2].rm, tbl[2].imm, tbl[2].hw);
        step();
        start = 1'b1;
        step();
        chk("discard_valid", out_valid, 32'h0);
        start = 1'b0; in_valid = 1'b0;
        step();
        chk("discard_noaccept", out_valid, 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            int   sel;
            logic [18:0] imm;
            reset     = ($urandom_range(0, 59) == 0);
            start     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 2);
            if (sel == 0) imm = 19'($urandom);
            else if (sel == 1) imm = 19'($urandom_range(0, 600) - 300);
            else imm = 19'($urandom_range(0, 65535));
            set_req(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, 2'($urandom));
            in_valid = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        step();

        // Reject counter saturates at 255
        start = 1'b1; step(); start = 1'b0; out_ready = 1'b1;
        set_req(3'd5, 5'd0, 5'd0, 5'd0, 19'd300, 2'd0);
        for (int i = 0; i < 262; i++) step();
        chk("errcnt_sat", err_count, 32'd255);
        in_valid = 1'b0; step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
